// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter and BTB entry layout.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Tag and target are held at full address width; users compare zero-extended values
    // so any PC_W/ENTRIES combination (including a zero-width tag) fits one entry type.
    localparam int unsigned BP_AW = 32;

    typedef struct packed {
        logic             valid;
        logic [BP_AW-1:0] tag;
        logic [BP_AW-1:0] target;
        ctr_t             ctr;
    } btb_entry_t;

    localparam int unsigned ENTRY_W = $bits(btb_entry_t);

    function automatic ctr_t next_ctr(ctr_t ctr, logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: two combinational read ports, one synchronous write port.
module btb_table
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [IDX_W-1:0]   rd_a_idx_i,
    output logic [ENTRY_W-1:0] rd_a_o,
    input  logic [IDX_W-1:0]   rd_b_idx_i,
    output logic [ENTRY_W-1:0] rd_b_o,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [ENTRY_W-1:0] wr_entry_i
);

    btb_entry_t table_q [ENTRIES];

    assign rd_a_o = table_q[rd_a_idx_i];
    assign rd_b_o = table_q[rd_b_idx_i];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            table_q[wr_idx_i] <= wr_entry_i;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolver with BTB: same-cycle fetch prediction, EX resolution/redirect,
// table training and saturating control/mispredict statistics.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int unsigned PC_W    = 9,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [31:0]       ex_imm,
    input  logic              ex_branch,
    input  logic              ex_jmp,
    input  logic              ex_jmpr,
    input  logic [31:0]       ex_alu_result,
    input  logic              ex_pred_taken,
    input  logic [PC_W-1:0]   ex_pred_target,
    output logic [31:0]       pc_imm,
    output logic [31:0]       pc_four,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_ctrl,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_SH = IDX_W + 2;

    logic [IDX_W-1:0]   if_idx, ex_idx;
    logic [BP_AW-1:0]   if_tag, ex_tag;
    logic [ENTRY_W-1:0] if_raw, ex_raw, wr_raw;
    btb_entry_t         if_ent, ex_ent, wr_ent;
    logic               wr_en;
    logic               if_hit, ex_hit;

    logic               is_ctrl, taken;
    logic [31:0]        act_tgt;
    logic [PC_W-1:0]    act_tgt_w;

    logic [STAT_W-1:0]  stat_ctrl_q, stat_ctrl_d;
    logic [STAT_W-1:0]  stat_miss_q, stat_miss_d;

    // A shift of the zero-extended PC yields tag 0 when no tag bits exist.
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_tag = BP_AW'(if_pc) >> TAG_SH;
    assign ex_tag = BP_AW'(ex_pc) >> TAG_SH;

    btb_table #(
        .ENTRIES (ENTRIES)
    ) u_btb (
        .clk_i      (clk),
        .reset_i    (reset),
        .rd_a_idx_i (if_idx),
        .rd_a_o     (if_raw),
        .rd_b_idx_i (ex_idx),
        .rd_b_o     (ex_raw),
        .wr_en_i    (wr_en),
        .wr_idx_i   (ex_idx),
        .wr_entry_i (wr_raw)
    );

    assign if_ent = if_raw;
    assign ex_ent = ex_raw;
    assign wr_raw = wr_ent;

    assign if_hit      = if_ent.valid && (if_ent.tag == if_tag);
    assign ex_hit      = ex_ent.valid && (ex_ent.tag == ex_tag);
    assign pred_taken  = if_hit && if_ent.ctr[1];
    assign pred_target = pred_taken ? if_ent.target[PC_W-1:0] : '0;

    logic unused_bits;
    assign unused_bits = ^if_ent.target;

    always_comb begin
        is_ctrl   = ex_branch | ex_jmp | ex_jmpr;
        taken     = (ex_branch & ex_alu_result[0]) | ex_jmp | ex_jmpr;
        pc_imm    = 32'(ex_pc) + ex_imm;
        pc_four   = 32'(ex_pc) + 32'd4;
        act_tgt   = ex_jmpr ? ex_alu_result : pc_imm;
        act_tgt_w = act_tgt[PC_W-1:0];

        mispredict  = 1'b0;
        redirect_pc = '0;
        if (ex_valid) begin
            mispredict  = (taken != ex_pred_taken) ||
                          (taken && (ex_pred_target != act_tgt_w));
            redirect_pc = taken ? act_tgt : pc_four;
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_ent = ex_ent;
        if (ex_valid) begin
            if (is_ctrl) begin
                if (ex_hit) begin
                    wr_en      = 1'b1;
                    wr_ent.ctr = next_ctr(ex_ent.ctr, taken);
                    if (taken) begin
                        wr_ent.target = BP_AW'(act_tgt_w);
                    end
                end else if (taken) begin
                    wr_en         = 1'b1;
                    wr_ent.valid  = 1'b1;
                    wr_ent.tag    = ex_tag;
                    wr_ent.target = BP_AW'(act_tgt_w);
                    wr_ent.ctr    = WT;
                end
            end else if (ex_pred_taken) begin
                // Non-control instruction hit a stale prediction: drop the aliasing entry.
                wr_en        = 1'b1;
                wr_ent.valid = 1'b0;
            end
        end
    end

    always_comb begin
        stat_ctrl_d = stat_ctrl_q;
        stat_miss_d = stat_miss_q;
        if (ex_valid && is_ctrl && (stat_ctrl_q != '1)) begin
            stat_ctrl_d = stat_ctrl_q + STAT_W'(1);
        end
        if (mispredict && (stat_miss_q != '1)) begin
            stat_miss_d = stat_miss_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_ctrl_q <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_ctrl_q <= stat_ctrl_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_ctrl = stat_ctrl_q;
    assign stat_miss = stat_miss_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a behavioural BTB model and per-cycle compare.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [8:0]  if_pc;
    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic [31:0] ex_imm;
    logic        ex_branch, ex_jmp, ex_jmpr;
    logic [31:0] ex_alu_result;
    logic        ex_pred_taken;
    logic [8:0]  ex_pred_target;

    logic        pred_taken;
    logic [8:0]  pred_target;
    logic [31:0] pc_imm, pc_four, redirect_pc;
    logic        mispredict;
    logic [15:0] stat_ctrl, stat_miss;

    logic        s_pred_taken;
    logic [8:0]  s_pred_target;
    logic [31:0] s_pc_imm, s_pc_four, s_redirect_pc;
    logic        s_mispredict;
    logic [3:0]  s_stat_ctrl, s_stat_miss;

    branch_predict_unit #(.PC_W(9), .ENTRIES(16), .STAT_W(16)) u_dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_branch(ex_branch), .ex_jmp(ex_jmp), .ex_jmpr(ex_jmpr),
        .ex_alu_result(ex_alu_result), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .pc_imm(pc_imm), .pc_four(pc_four),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_ctrl(stat_ctrl), .stat_miss(stat_miss)
    );

    branch_predict_unit #(.PC_W(9), .ENTRIES(16), .STAT_W(4)) u_sat (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(s_pred_taken), .pred_target(s_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_branch(ex_branch), .ex_jmp(ex_jmp), .ex_jmpr(ex_jmpr),
        .ex_alu_result(ex_alu_result), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .pc_imm(s_pc_imm), .pc_four(s_pc_four),
        .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
        .stat_ctrl(s_stat_ctrl), .stat_miss(s_stat_miss)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model: one slot per index, counters kept as plain integers 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int unsigned n_ctrl, n_miss;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int slot(input logic [8:0] pc);
        return (int'(pc) / 4) % 16;
    endfunction

    function automatic int unsigned tag_of(input logic [8:0] pc);
        return int'(pc) / 64;
    endfunction

    function automatic bit m_hit(input logic [8:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_ptaken(input logic [8:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptarget(input logic [8:0] pc);
        return m_ptaken(pc) ? m_tgt[slot(pc)] : 32'd0;
    endfunction

    function automatic bit e_ctrl();
        return ex_branch || ex_jmp || ex_jmpr;
    endfunction

    function automatic bit e_taken();
        return (ex_branch && ex_alu_result[0]) || ex_jmp || ex_jmpr;
    endfunction

    function automatic logic [31:0] e_target();
        logic [31:0] base = {23'd0, ex_pc};
        return ex_jmpr ? ex_alu_result : base + ex_imm;
    endfunction

    function automatic bit e_mis();
        logic [31:0] pt = {23'd0, ex_pred_target};
        if (!ex_valid) return 1'b0;
        return (e_taken() != ex_pred_taken) || (e_taken() && (pt != (e_target() & 32'h1FF)));
    endfunction

    function automatic logic [31:0] e_redirect();
        if (!ex_valid) return 32'd0;
        return e_taken() ? e_target() : {23'd0, ex_pc} + 32'd4;
    endfunction

    function automatic logic [31:0] capped(input int unsigned n, input int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_step();
        int i;
        i = slot(ex_pc);
        if (reset) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 1'b0; m_tag[k] = 0; m_tgt[k] = 32'd0; m_ctr[k] = 0;
            end
            n_ctrl = 0;
            n_miss = 0;
        end else if (ex_valid) begin
            if (e_mis()) n_miss++;
            if (e_ctrl()) begin
                n_ctrl++;
                if (m_hit(ex_pc)) begin
                    if (e_taken()) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = e_target() & 32'h1FF;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (e_taken()) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(ex_pc);
                    m_tgt[i]   = e_target() & 32'h1FF;
                    m_ctr[i]   = 2;
                end
            end else if (ex_pred_taken) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pred_taken",  32'(pred_taken),  32'(m_ptaken(if_pc)));
            chk("pred_target", 32'(pred_target), m_ptarget(if_pc));
            chk("pc_imm",      pc_imm,           {23'd0, ex_pc} + ex_imm);
            chk("pc_four",     pc_four,          {23'd0, ex_pc} + 32'd4);
            chk("mispredict",  32'(mispredict),  32'(e_mis()));
            chk("redirect_pc", redirect_pc,      e_redirect());
            chk("stat_ctrl",   32'(stat_ctrl),   capped(n_ctrl, 65535));
            chk("stat_miss",   32'(stat_miss),   capped(n_miss, 65535));
            chk("sat_ctrl",    32'(s_stat_ctrl), capped(n_ctrl, 15));
            chk("sat_miss",    32'(s_stat_miss), capped(n_miss, 15));
        end
    end

    // One clock of stimulus; auto_pred feeds the model's prediction for ex_pc down the pipe.
    task automatic cyc(input bit rst, input logic [8:0] ipc, input bit v, input logic [8:0] pc,
                       input logic [31:0] imm, input bit br, input bit j, input bit jr,
                       input logic [31:0] alu, input bit auto_pred, input bit ptk,
                       input logic [8:0] ptg);
        logic [31:0] mt;
        @(posedge clk);
        model_step();
        #1;
        reset = rst; if_pc = ipc; ex_valid = v; ex_pc = pc; ex_imm = imm;
        ex_branch = br; ex_jmp = j; ex_jmpr = jr; ex_alu_result = alu;
        if (auto_pred) begin
            mt = m_ptarget(pc);
            ex_pred_taken  = m_ptaken(pc);
            ex_pred_target = mt[8:0];
        end else begin
            ex_pred_taken  = ptk;
            ex_pred_target = ptg;
        end
    endtask

    task automatic idle(input logic [8:0] ipc);
        cyc(1'b0, ipc, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_imm = '0;
        ex_branch = 1'b0; ex_jmp = 1'b0; ex_jmpr = 1'b0; ex_alu_result = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
        for (int k = 0; k < 16; k++) begin
            m_valid[k] = 1'b0; m_tag[k] = 0; m_tgt[k] = 32'd0; m_ctr[k] = 0;
        end
        n_ctrl = 0; n_miss = 0;

        cyc(1'b1, 9'h0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0);
        chk_on = 1'b1;
        cyc(1'b1, 9'h0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0);
        idle(9'h010);
        settle();
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_target", 32'(pred_target), 32'd0);
        chk("rst_stat_ctrl", 32'(stat_ctrl), 32'd0);
        chk("rst_stat_miss", 32'(stat_miss), 32'd0);

        // First taken branch allocates; lookup of the same index this cycle sees old contents.
        cyc(1'b0, 9'h010, 1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0, 9'h0);
        settle();
        chk("alloc_mispredict", 32'(mispredict), 32'd1);
        chk("alloc_redirect", redirect_pc, 32'h30);
        chk("alloc_no_bypass", 32'(pred_taken), 32'd0);
        idle(9'h010);
        settle();
        chk("alloc_pred_taken", 32'(pred_taken), 32'd1);
        chk("alloc_pred_target", 32'(pred_target), 32'h30);
        chk("alloc_stat_miss", 32'(stat_miss), 32'd1);

        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 9'h010, 1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 9'h0);
            if (k == 0) begin
                settle();
                chk("nt_mispredict", 32'(mispredict), 32'd1);
                chk("nt_redirect", redirect_pc, 32'h14);
            end
        end
        idle(9'h010);
        settle();
        chk("nt_pred_taken", 32'(pred_taken), 32'd0);
        chk("nt_stat_ctrl", 32'(stat_ctrl), 32'd4);
        chk("nt_stat_miss", 32'(stat_miss), 32'd2);

        // From a saturated 00 two takens are needed before the entry predicts taken again.
        cyc(1'b0, 9'h010, 1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 1'b0, 9'h0);
        cyc(1'b0, 9'h010, 1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 1'b0, 9'h0);
        settle();
        chk("climb_pred_still_nt", 32'(pred_taken), 32'd0);
        idle(9'h010);
        settle();
        chk("climb_pred_taken", 32'(pred_taken), 32'd1);

        cyc(1'b0, 9'h040, 1'b1, 9'h040, 32'hC0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0);
        settle();
        chk("jal_redirect", redirect_pc, 32'h100);
        cyc(1'b0, 9'h040, 1'b1, 9'h040, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1A4, 1'b0, 1'b1, 9'h100);
        settle();
        chk("jalr_mispredict", 32'(mispredict), 32'd1);
        chk("jalr_redirect", redirect_pc, 32'h1A4);
        idle(9'h040);
        settle();
        chk("jalr_new_target", 32'(pred_target), 32'h1A4);
        cyc(1'b0, 9'h040, 1'b1, 9'h040, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11A4, 1'b0, 1'b1, 9'h1A4);
        settle();
        chk("jalr_trunc_mispredict", 32'(mispredict), 32'd0);
        chk("jalr_full_redirect", redirect_pc, 32'h11A4);

        idle(9'h080);
        settle();
        chk("tag_miss_pred", 32'(pred_taken), 32'd0);

        cyc(1'b0, 9'h010, 1'b0, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 1'b1, 9'h0);
        settle();
        chk("invalid_mispredict", 32'(mispredict), 32'd0);
        chk("invalid_redirect", redirect_pc, 32'd0);

        cyc(1'b0, 9'h1FC, 1'b1, 9'h1FC, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 1'b1, 9'h1EC);
        settle();
        chk("wrap_pc_imm", pc_imm, 32'h1EC);
        chk("wrap_pc_four", pc_four, 32'h200);
        chk("wrap_mispredict", 32'(mispredict), 32'd0);

        cyc(1'b0, 9'h010, 1'b1, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 9'h030);
        settle();
        chk("alias_mispredict", 32'(mispredict), 32'd1);
        chk("alias_redirect", redirect_pc, 32'h14);
        idle(9'h010);
        settle();
        chk("alias_invalidated", 32'(pred_taken), 32'd0);

        for (int k = 0; k < 20; k++) begin
            logic [8:0] pc;
            pc = 9'(32'h100 + 32'(k) * 4);
            cyc(1'b0, pc, 1'b1, pc, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 9'h0);
        end
        idle(9'h010);
        settle();
        chk("sat_stat_miss", 32'(s_stat_miss), 32'd15);
        chk("sat_stat_ctrl", 32'(s_stat_ctrl), 32'd15);
        chk("wide_stat_miss", 32'(stat_miss), 32'd27);

        // Reset wins over an allocating update in the same cycle.
        cyc(1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0, 9'h0);
        idle(9'h020);
        settle();
        chk("rst_upd_pred", 32'(pred_taken), 32'd0);
        chk("rst_upd_ctrl", 32'(stat_ctrl), 32'd0);
        chk("rst_upd_miss", 32'(stat_miss), 32'd0);
        chk("rst_upd_sat_miss", 32'(s_stat_miss), 32'd0);
        idle(9'h040);
        idle(9'h1FC);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch resolver: resolves branches/jumps in EX and adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Fetch side: same-cycle prediction (taken + target) for the current fetch PC.
- EX side: computes the actual outcome, detects mispredictions, produces the corrected PC, trains the table, and keeps saturating statistics counters.

Parameters:
- PC_W, 9, PC width in bits; byte address, word aligned.
- ENTRIES, 16, BTB depth; power of two, at least 2; IDX_W = log2(ENTRIES).
- STAT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_pc  in  PC_W  fetch PC to predict
- pred_taken  out  1  prediction for if_pc
- pred_target  out  PC_W  predicted target; 0 when pred_taken=0
- ex_valid  in  1  EX stage holds a real instruction
- ex_pc  in  PC_W  PC of the EX instruction
- ex_imm  in  32  immediate
- ex_branch  in  1  conditional branch
- ex_jmp  in  1  jal
- ex_jmpr  in  1  jalr
- ex_alu_result  in  32  bit0 = branch condition; full value = jalr target
- ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction
- ex_pred_target  in  PC_W  predicted target carried down the pipe
- pc_imm  out  32  zero-extended ex_pc + ex_imm
- pc_four  out  32  zero-extended ex_pc + 4
- mispredict  out  1  flush IF/ID and redirect
- redirect_pc  out  32  corrected next PC; valid when mispredict=1
- stat_ctrl  out  STAT_W  count of resolved control instructions
- stat_miss  out  STAT_W  count of mispredictions

Behaviour:
- Table fields:
  - Index = pc[IDX_W+1:2].
  - Tag = pc[PC_W-1:IDX_W+2]. Tag may be zero-width; in that case tag compare is always true.
  - Per entry: valid, tag, target[PC_W], ctr[1:0].
- Lookup (combinational from registered table):
  - hit = valid and tag match.
  - pred_taken = hit and ctr[1].
  - pred_target = stored target when pred_taken=1, else 0.
- Resolution (combinational, active only when ex_valid=1):
  - taken = (ex_branch and ex_alu_result[0]) or ex_jmp or ex_jmpr.
  - Actual target: ex_jmpr ? ex_alu_result : pc_imm.
  - Compare on the low PC_W bits of the actual target; store that truncated value.
- mispredict = ex_valid and (taken != ex_pred_taken, or taken and ex_pred_target != actual target[PC_W-1:0]).
- redirect_pc = taken ? actual target : pc_four.
- When ex_valid=0: mispredict=0 and redirect_pc=0.
- Training, applied at the clk edge when ex_valid=1, at index/tag of ex_pc:
  - Control instruction, hit: ctr increments on taken, decrements on not taken. Saturates: 11 stays 11 on taken, 00 stays 00 on not taken. On taken, target is rewritten.
  - Control instruction, miss, taken: allocate the entry (overwriting any previous contents) with valid=1, new tag, target, ctr=10.
  - Control instruction, miss, not taken: no table change.
  - Non-control instruction with ex_pred_taken=1 (alias): mispredict=1, redirect to pc_four, and the indexed entry's valid is cleared.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents; no bypass.
- Statistics:
  - stat_ctrl increments on each ex_valid control instruction.
  - stat_miss increments on each mispredict.
  - Both saturate at all-ones.
- Reset:
  - All valid bits cleared; ctr and target reset to 00 and 0.
  - Both statistics counters reset to 0.
  - Outputs the cycle after reset: pred_taken=0, pred_target=0.
  - Reset asserted mid-stream overrides any same-cycle update.
- Latency:
  - Prediction and resolution are 0-cycle (combinational).
  - Table and counter updates are visible on the following cycle.

Decomposition:
- Shared package bp_pkg holds:
  - ctr_t (2-bit) and its constants: SNT=00, WNT=01, WT=10, ST=11.
  - The btb_entry_t struct {valid, tag, target, ctr}.
  - The function next_ctr(ctr, taken).
- One sub-module, btb_table:
  - Register array of entries.
  - Combinational read port and synchronous write port.
  - Synchronous clear on reset.
- Resolution and statistics logic stay in the top module.

Test Plan:
- Reset, then if_pc=0x010 -> pred_taken=0, pred_target=0, stat_ctrl=0, stat_miss=0.
- Branch at ex_pc=0x010, ex_imm=0x20, alu_result[0]=1, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x30, stat_miss=1. Next cycle, if_pc=0x010 gives pred_taken=1, pred_target=0x30 (ctr=10).
- Same branch resolved not-taken 3 times with correct predictions supplied -> ctr walks 10->01->00->00 (saturates). pred_taken=0 from the first decrement onward. Each not-taken with ex_pred_taken=1 redirects to pc_four=0x014.
- jalr at ex_pc=0x040, alu_result=0x1A4, ex_pred_taken=1, ex_pred_target=0x100 -> mispredict=1, redirect_pc=0x1A4, entry target updated to 0x1A4.
- Alias: add at ex_pc=0x010 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x014, entry invalidated. Next cycle, lookup of 0x010 gives pred_taken=0.
- Counter saturation with STAT_W=4: 20 mispredicting branches -> stat_miss=15. Reset asserted in the same cycle as an allocating update -> entry stays invalid, counters read 0.
